// File: rtl/shift_reg_universal.sv
// Universal shift register with single-step modes and a burst engine.
// A burst repeats the latched mode N times from one start pulse.
module shift_reg_universal #(
    parameter  int WIDTH = 4,
    localparam int AW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             din_serie,
    input  logic [WIDTH-1:0] din,
    input  logic             start,
    input  logic [AW-1:0]    amount,
    output logic [WIDTH-1:0] dout,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic             busy,
    output logic             done
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHR  = 3'b010;
    localparam logic [2:0] M_SHL  = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_ROL  = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    logic [0:0]       state_q, state_d;
    logic [AW-1:0]    count_q, count_d;
    logic [2:0]       mode_l_q, mode_l_d;
    logic [WIDTH-1:0] din_l_q, din_l_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             done_q, done_d;

    // One step of a mode applied to the current contents.
    function automatic logic [WIDTH-1:0] step(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] cur,
        input logic             sin,
        input logic [WIDTH-1:0] ld
    );
        logic [WIDTH-1:0] r;
        r = cur;
        case (m)
            M_HOLD:  r = cur;
            M_LOAD:  r = ld;
            M_SHR:   r = {sin, cur[WIDTH-1:1]};
            M_SHL:   r = {cur[WIDTH-2:0], sin};
            M_ROR:   r = {cur[0], cur[WIDTH-1:1]};
            M_ROL:   r = {cur[WIDTH-2:0], cur[WIDTH-1]};
            M_ASR:   r = {cur[WIDTH-1], cur[WIDTH-1:1]};
            M_CLR:   r = '0;
            default: r = cur;
        endcase
        return r;
    endfunction

    // Next state: burst step beats start, start beats single step.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mode_l_d = mode_l_q;
        din_l_d  = din_l_q;
        dout_d   = dout_q;
        done_d   = 1'b0;
        if (state_q == BURST) begin
            dout_d  = step(mode_l_q, dout_q, din_serie, din_l_q);
            count_d = count_q - AW'(1);
            if (count_q == AW'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if (start) begin
            mode_l_d = mode;
            din_l_d  = din;
            if (amount != '0) begin
                state_d = BURST;
                count_d = amount;
            end else begin
                done_d = 1'b1;
            end
        end else if (en) begin
            dout_d = step(mode, dout_q, din_serie, din);
        end
    end

    // Register update with synchronous reset that also aborts a burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            mode_l_q <= M_HOLD;
            din_l_q  <= '0;
            dout_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mode_l_q <= mode_l_d;
            din_l_q  <= din_l_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
        end
    end

    assign dout     = dout_q;
    assign sout_lsb = dout_q[0];
    assign sout_msb = dout_q[WIDTH-1];
    assign busy     = (state_q == BURST);
    assign done     = done_q;

endmodule

// File: doc/shift_reg_universal.md
# shift_reg_universal

Parametrised universal shift register: the successor to the team's 4-bit load/shift-right register. It adds configurable width, eight operating modes (left, right, rotate and arithmetic shifts, clear) and an autonomous burst engine that performs N shift steps from a single start pulse, with busy/done handshake. It sits between parallel datapaths and serial links, serving as a serializer/deserializer or barrel-style shifter.

## Interface
- WIDTH, default 4: register width in bits; legal range ≥ 2.
- AW, default $clog2(WIDTH+1): width of the burst amount field (derived, not overridden).

- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  enables single-step mode operation when idle.
- mode  input  3  operation select (see Operation).
- din_serie  input  1  serial input bit for shift modes.
- din  input  WIDTH  parallel load data.
- start  input  1  launches a burst when idle.
- amount  input  AW  number of burst steps, sampled with start.
- dout  output  WIDTH  register contents.
- sout_lsb  output  1  equals dout[0] (serial out for right shifts).
- sout_msb  output  1  equals dout[WIDTH-1] (serial out for left shifts).
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle pulse when a burst completes.

## Operation
- Modes:
  - 000 hold.
  - 001 parallel load, dout<=din.
  - 010 shift right, dout<={din_serie, dout[W-1:1]}.
  - 011 shift left, dout<={dout[W-2:0], din_serie}.
  - 100 rotate right.
  - 101 rotate left.
  - 110 arithmetic shift right: MSB replicated, din_serie ignored.
  - 111 clear, dout<=0.
- Priority per edge: reset > burst step > start acceptance > en single step > hold.
- Idle, start=0, en=1: execute mode once per edge. With en=0, dout holds.
- Idle, start=1:
  - Latch mode and amount; no data operation on this edge.
  - If amount≠0: busy<=1 and count<=amount.
  - If amount=0: busy stays 0, done<=1 next cycle, dout unchanged.
- Burst (busy=1):
  - One step of the latched mode per edge.
  - en, mode, start, amount and din are ignored. din_serie is sampled live each step.
  - count decrements per step. On the step where count reaches 0: busy<=0, done<=1.
- start while busy is ignored. It is not queued.
- Latched mode 000/001/111 in a burst: the op is applied amount times (idempotent). Hold yields no change; load reloads the din value latched at start.
- amount may exceed WIDTH. Steps are simply repeated, so rotates wrap (e.g. rotate by WIDTH returns the original).
- State machine:
  - IDLE→BURST on start with amount≠0.
  - BURST→IDLE on last step.
  - IDLE→IDLE (done pulse) on start with amount=0.

## Timing
- Reset values: dout=0, busy=0, done=0, count=0, state IDLE. sout_lsb and sout_msb are therefore 0.
- Reset mid-burst aborts immediately: outputs return to reset values at that edge, and no done pulse is produced.
- Single-step latency: mode effect is visible in dout 1 cycle after the sampling edge.
- Burst, with start sampled at edge k and amount=N≥1:
  - busy is high after edge k through edge k+N.
  - Steps occur at edges k+1..k+N.
  - done is high for exactly the cycle after edge k+N; busy is 0 in that cycle.
  - A new start is accepted in the done cycle.
- sout_lsb/sout_msb are combinational from dout (no extra latency).
- done never asserts without a preceding accepted start.

## Test plan
- Reset and load, WIDTH=4: reset=1 → dout=0000, busy=0, done=0. Then en=1, mode=001, din=1011 → dout=1011 next cycle.
- Single-step modes from 1011 with din_serie=1:
  - shift right → 1101; shift left → 0111.
  - rotate right → 1101 with din_serie=0; rotate left → 0111.
  - arithmetic right from 1000 → 1100.
  - clear → 0000.
  - en=0 holds.
- Burst rotate left: dout=0001, start with mode=101, amount=3 → busy high 3 cycles, dout 0010/0100/1000, done pulse one cycle after, total 4 cycles start→done.
- Serializer burst: dout=1010, mode=010, amount=4, din_serie=0 → sout_lsb sequence 0,1,0,1 across steps, final dout=0000, done once. start pulses mid-burst are ignored, and mode changes mid-burst have no effect.
- Edge cases:
  - amount=0 → done next cycle, busy never high, dout unchanged.
  - amount=7 rotate right on 0001 → 0010.
  - Back-to-back start in done cycle is accepted.
- Reset mid-burst: assert reset at step 2 of a 4-step burst → dout=0, busy=0, no done afterwards.
